// File: rtl/serial_pkg.sv
// Shared types and constants for the serial byte receiver.
// The state enum is also used by benches that observe the debug state output.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam logic LINE_IDLE       = 1'b1;
  localparam int   FRAME_DATA_BITS = 8;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous input.
// Both flops reset to RESET_VAL so the synchronized line starts in a known level.
module bit_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_byte_receiver.sv
// 8N1 LSB-first serial receiver feeding the byte_memory latch bank.
// data changes only on a good stop bit, on the same edge store rises for one cycle.
module serial_byte_receiver
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = FRAME_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] data,
  output logic                 store,
  output logic                 busy,
  output logic                 frame_error,
  output rx_state_t            dbg_state
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

  // store and frame_error are plain strobes: no ready/back-pressure exists;
  // the consumer must capture data in the cycle store is high.

  logic                 rx;
  rx_state_t            state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [2:0]           bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 store_n, ferr_n;

  bit_sync #(.RESET_VAL(LINE_IDLE)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (serial_in),
    .q     (rx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      data        <= '0;
      store       <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_cnt     <= bit_cnt_n;
      shreg       <= shreg_n;
      data        <= data_n;
      store       <= store_n;
      frame_error <= ferr_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CNT_W'(1);
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    data_n    = data;
    store_n   = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n     = '0;
        bit_cnt_n = '0;
        if (rx == 1'b0) state_n = START;
      end
      START: begin
        // A line that is high again by mid start bit was only a glitch.
        if (cnt == HALF_LAST) begin
          cnt_n   = '0;
          state_n = rx ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n            = '0;
          shreg_n[bit_cnt] = rx;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_n = '0;
            state_n   = STOP;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (rx) begin
            data_n  = shreg;
            store_n = 1'b1;
          end else begin
            ferr_n = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_serial_byte_receiver.sv
// Directed bench for serial_byte_receiver: frame-level timing model plus literal pins.
// The model predicts store/frame_error/busy/data from frame start times and bit values.
module tb_serial_byte_receiver;
  import serial_pkg::*;

  localparam int CPB = 16;
  localparam int LAT = 2 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_in;
  logic [7:0] data;
  logic       store, busy, frame_error;
  rx_state_t  dbg_state;

  serial_byte_receiver #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .serial_in   (serial_in),
    .data        (data),
    .store       (store),
    .busy        (busy),
    .frame_error (frame_error),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // model state
  typedef struct { int cyc; bit is_store; logic [7:0] val; } ev_t;
  typedef struct { int lo; int hi; } win_t;
  ev_t        ev_q[$];
  win_t       win_q[$];
  logic [7:0] exp_q[$];
  int         store_cyc_q[$];
  logic [7:0] model_data = 8'h00;
  int         n_checks = 0;
  int         n_err = 0;
  int         n_ferr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cyc %0d", name, act, exp, cyc);
    end
  endtask

  // driver tasks (called right after a falling edge)
  task automatic idle(input int n);
    serial_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, output int c);
    c = cyc;
    ev_q.push_back('{cyc: c + 1 + LAT, is_store: stop, val: b});
    win_q.push_back('{lo: c + 3, hi: c + 1 + LAT});
    if (stop) exp_q.push_back(b);
    else win_q.push_back('{lo: c + 2 + LAT, hi: c + 2 + LAT + CPB / 2});
    serial_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    serial_in = stop;
    repeat (CPB) @(negedge clk);
  endtask

  // scoreboard / compare process
  initial begin
    logic exp_store, exp_ferr, exp_busy;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        ev_q.delete();
        win_q.delete();
        model_data = 8'h00;
      end
      exp_store = 1'b0;
      exp_ferr  = 1'b0;
      exp_busy  = 1'b0;
      foreach (ev_q[i]) begin
        if (ev_q[i].cyc == cyc) begin
          if (ev_q[i].is_store) begin
            exp_store  = 1'b1;
            model_data = ev_q[i].val;
          end else begin
            exp_ferr = 1'b1;
          end
        end
      end
      foreach (win_q[i])
        if (cyc >= win_q[i].lo && cyc < win_q[i].hi) exp_busy = 1'b1;
      check("store", 32'(store), 32'(exp_store));
      check("frame_error", 32'(frame_error), 32'(exp_ferr));
      check("busy", 32'(busy), 32'(exp_busy));
      check("data", 32'(data), 32'(model_data));
      if (store === 1'b1) begin
        store_cyc_q.push_back(cyc);
        check("store_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("store_byte", 32'(data), 32'(exp_q.pop_front()));
      end
      if (frame_error === 1'b1) n_ferr++;
    end
  end

  // directed sequence
  initial begin
    int c, c_a5, sz;
    reset     = 1'b1;
    serial_in = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    check("rst_data", 32'(data), 32'h00);
    check("rst_store", 32'(store), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ferr", 32'(frame_error), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    reset = 1'b0;
    idle(500);
    check("idle_stores", 32'(store_cyc_q.size()), 32'd0);
    check("idle_ferr", 32'(n_ferr), 32'd0);

    send_frame(8'hA5, 1'b1, c_a5);
    idle(20);
    check("a5_count", 32'(store_cyc_q.size()), 32'd1);
    check("a5_data", 32'(data), 32'hA5);
    if (store_cyc_q.size() > 0)
      check("a5_latency", 32'(store_cyc_q[$] - (c_a5 + 1)), 32'd154);

    send_frame(8'h3C, 1'b0, c);
    idle(30);
    check("3c_ferr", 32'(n_ferr), 32'd1);
    check("3c_no_store", 32'(store_cyc_q.size()), 32'd1);
    check("3c_data_held", 32'(data), 32'hA5);

    c = cyc;
    win_q.push_back('{lo: c + 3, hi: c + 3 + CPB / 2});
    serial_in = 1'b0;
    repeat (4) @(negedge clk);
    idle(30);
    check("glitch_no_store", 32'(store_cyc_q.size()), 32'd1);
    check("glitch_no_ferr", 32'(n_ferr), 32'd1);
    check("glitch_state", 32'(dbg_state), 32'(IDLE));

    send_frame(8'h01, 1'b1, c);
    send_frame(8'hFF, 1'b1, c);
    send_frame(8'h80, 1'b1, c);
    idle(20);
    sz = store_cyc_q.size();
    check("b2b_count", 32'(sz), 32'd4);
    if (sz >= 4) begin
      check("b2b_gap1", 32'(store_cyc_q[sz-2] - store_cyc_q[sz-3]), 32'd160);
      check("b2b_gap2", 32'(store_cyc_q[sz-1] - store_cyc_q[sz-2]), 32'd160);
    end
    check("b2b_data", 32'(data), 32'h80);

    // partial 0x5A cut by reset halfway into bit 4
    c = cyc;
    win_q.push_back('{lo: c + 3, hi: c + 100000});
    serial_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      serial_in = 1'(8'h5A >> i);
      repeat (CPB) @(negedge clk);
    end
    serial_in = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    check("midrst_data", 32'(data), 32'h00);
    check("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(20);
    check("midrst_no_store", 32'(store_cyc_q.size()), 32'd4);

    send_frame(8'h5A, 1'b1, c);
    idle(20);
    check("5a_data", 32'(data), 32'h5A);
    check("5a_count", 32'(store_cyc_q.size()), 32'd5);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
